// File: rtl/rat_io_pkg.sv
// Shared constants for the RAT MCU port-mapped interrupt controller:
// default port IDs, mode encoding and the priority-encode helper.
package rat_io_pkg;

    localparam logic [7:0] DEF_MASK_PORT = 8'h30;
    localparam logic [7:0] DEF_MODE_PORT = 8'h31;
    localparam logic [7:0] DEF_CLR_PORT  = 8'h32;
    localparam logic [7:0] DEF_STAT_PORT = 8'h33;
    localparam logic [7:0] DEF_ID_PORT   = 8'h34;

    localparam logic [7:0] ID_NONE = 8'hFF;
    localparam int         MAX_CH  = 8;

    localparam logic MODE_EDGE  = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    // Channel 0 is the highest priority, so the lowest set bit wins.
    function automatic logic [7:0] first_set_id(input logic [MAX_CH-1:0] v);
        logic [7:0] id;
        id = ID_NONE;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) id = 8'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_debounce.sv
// One interrupt channel front end: 2-FF synchroniser, stability counter
// and a registered one-cycle pulse on each debounced rising transition.
module irq_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic level,
    output logic rise
);

    localparam int           CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= irq_in;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Multi-source interrupt controller for the RAT MCU: per-channel debounce,
// edge/level pending latch, maskable priority INT and IN/OUT port registers.
module rat_intr_ctrl
    import rat_io_pkg::*;
#(
    parameter int         NUM_CH          = 4,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] MASK_PORT       = DEF_MASK_PORT,
    parameter logic [7:0] MODE_PORT       = DEF_MODE_PORT,
    parameter logic [7:0] CLR_PORT        = DEF_CLR_PORT,
    parameter logic [7:0] STAT_PORT       = DEF_STAT_PORT,
    parameter logic [7:0] ID_PORT         = DEF_ID_PORT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_CH-1:0] IRQ_IN,
    input  logic              IO_STRB,
    input  logic [7:0]        PORT_ID,
    input  logic [7:0]        OUT_PORT,
    output logic [7:0]        IN_DATA,
    output logic              INT,
    output logic [NUM_CH-1:0] PENDING
);

    logic [NUM_CH-1:0] level, rise;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] clr;
    logic              int_q, int_d;
    logic [MAX_CH-1:0] mask_x, mode_x, pend_x, act_x;
    logic              unused_out_port;

    assign unused_out_port = ^OUT_PORT;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        irq_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (CLK),
            .rst_n (RST_N),
            .irq_in(IRQ_IN[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        clr    = '0;
        if (IO_STRB && PORT_ID == MASK_PORT) mask_d = OUT_PORT[NUM_CH-1:0];
        if (IO_STRB && PORT_ID == MODE_PORT) mode_d = OUT_PORT[NUM_CH-1:0];
        if (IO_STRB && PORT_ID == CLR_PORT)  clr    = OUT_PORT[NUM_CH-1:0];

        // OR-ing the rise in after the clear lets a same-cycle set win.
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode_q[i] == MODE_LEVEL) pending_d[i] = level[i];
            else                         pending_d[i] = (pending_q[i] & ~clr[i]) | rise[i];
        end

        int_d = |(pending_q & mask_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mask_q    <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            int_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            int_q     <= int_d;
        end
    end

    always_comb begin
        mask_x = '0;
        mode_x = '0;
        pend_x = '0;
        act_x  = '0;
        mask_x[NUM_CH-1:0] = mask_q;
        mode_x[NUM_CH-1:0] = mode_q;
        pend_x[NUM_CH-1:0] = pending_q;
        act_x[NUM_CH-1:0]  = pending_q & mask_q;

        if      (PORT_ID == MASK_PORT) IN_DATA = mask_x;
        else if (PORT_ID == MODE_PORT) IN_DATA = mode_x;
        else if (PORT_ID == STAT_PORT) IN_DATA = pend_x;
        else if (PORT_ID == ID_PORT)   IN_DATA = first_set_id(act_x);
        else                           IN_DATA = 8'h00;
    end

    assign INT     = int_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl with NUM_CH=4, DEBOUNCE_CYCLES=4.
module tb_rat_intr_ctrl;

    localparam int NC = 4;
    localparam int DB = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [NC-1:0] IRQ_IN;
    logic          IO_STRB;
    logic [7:0]    PORT_ID;
    logic [7:0]    OUT_PORT;
    logic [7:0]    IN_DATA;
    logic          INT;
    logic [NC-1:0] PENDING;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    logic [NC-1:0] m_pend, m_level, m_rise, m_mask, m_mode;
    logic          m_int;
    logic [NC-1:0] m_hist[$];

    rat_intr_ctrl #(
        .NUM_CH(NC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .IRQ_IN  (IRQ_IN),
        .IO_STRB (IO_STRB),
        .PORT_ID (PORT_ID),
        .OUT_PORT(OUT_PORT),
        .IN_DATA (IN_DATA),
        .INT     (INT),
        .PENDING (PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pend  = '0;
        m_level = '0;
        m_rise  = '0;
        m_mask  = '0;
        m_mode  = '0;
        m_int   = 1'b0;
        m_hist.delete();
        for (int k = 0; k < DB + 2; k++) m_hist.push_front('0);
    endtask

    // A channel's debounced level flips once the last DB synchronised
    // samples (raw samples delayed by two edges) all disagree with it.
    task automatic model_edge();
        logic [NC-1:0] clr, nxt;
        bit            flip;
        clr = (IO_STRB && PORT_ID == 8'h32) ? OUT_PORT[NC-1:0] : '0;
        for (int c = 0; c < NC; c++)
            nxt[c] = m_mode[c] ? m_level[c] : ((m_pend[c] & ~clr[c]) | m_rise[c]);
        m_int  = |(m_pend & m_mask);
        m_pend = nxt;
        m_hist.push_front(IRQ_IN);
        void'(m_hist.pop_back());
        m_rise = '0;
        for (int c = 0; c < NC; c++) begin
            flip = 1'b1;
            for (int j = 2; j < DB + 2; j++) if (m_hist[j][c] == m_level[c]) flip = 1'b0;
            if (flip) begin
                m_level[c] = ~m_level[c];
                m_rise[c]  = m_level[c];
            end
        end
        if (IO_STRB && PORT_ID == 8'h30) m_mask = OUT_PORT[NC-1:0];
        if (IO_STRB && PORT_ID == 8'h31) m_mode = OUT_PORT[NC-1:0];
    endtask

    function automatic logic [7:0] m_in_data(input logic [7:0] p);
        logic [NC-1:0] act;
        act = m_pend & m_mask;
        case (p)
            8'h30: return {4'b0, m_mask};
            8'h31: return {4'b0, m_mode};
            8'h33: return {4'b0, m_pend};
            8'h34: begin
                for (int i = 0; i < NC; i++) if (act[i]) return 8'(i);
                return 8'hFF;
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        if (RST_N) model_edge();
        @(negedge CLK);
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        IO_STRB  = 1'b1;
        PORT_ID  = port;
        OUT_PORT = data;
        step();
        IO_STRB  = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IRQ_IN = '0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
        model_reset();
        repeat (3) @(negedge CLK);
        n_checks++;
        if (PENDING !== 4'h0) begin n_fail++; $display("FAIL reset_pending: got %h want %h", PENDING, 4'h0); end
        n_checks++;
        if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", INT); end
        PORT_ID = 8'h30; #1;
        n_checks++;
        if (IN_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_mask_read: got %h want 00", IN_DATA); end
        PORT_ID = 8'h34; #1;
        n_checks++;
        if (IN_DATA !== 8'hFF) begin n_fail++; $display("FAIL reset_id_read: got %h want ff", IN_DATA); end
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        PORT_ID = 8'h35; #1;
        n_checks++;
        if ({PENDING, INT, IN_DATA} !== 13'h0) begin
            n_fail++; $display("FAIL reset_release: pend %h int %b other_port %h, want all 0", PENDING, INT, IN_DATA);
        end
    endtask

    task automatic test_glitch();
        wr(8'h30, 8'h0F);
        IRQ_IN[1] = 1'b1;
        repeat (3) step();
        IRQ_IN[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if ({PENDING, INT} !== 5'b0) begin
                n_fail++; $display("FAIL glitch_rejected: cycle %0d pend %h int %b, want 0/0", k, PENDING, INT);
            end
        end
    endtask

    task automatic test_edge_latency();
        IRQ_IN[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6) begin
                n_checks++;
                if (PENDING !== 4'b0000) begin n_fail++; $display("FAIL edge_early: edge 6 pend %b want 0000", PENDING); end
            end
            if (e == 7) begin
                n_checks++;
                if (PENDING !== 4'b0100 || INT !== 1'b0) begin
                    n_fail++; $display("FAIL edge_pending: edge 7 pend %b int %b want 0100/0", PENDING, INT);
                end
            end
            if (e == 8) begin
                PORT_ID = 8'h34; #1;
                n_checks++;
                if (INT !== 1'b1 || IN_DATA !== 8'h02) begin
                    n_fail++; $display("FAIL edge_int_id: edge 8 int %b id %h want 1/02", INT, IN_DATA);
                end
            end
        end
    endtask

    task automatic test_priority_w1c();
        wr(8'h32, 8'h04);
        IRQ_IN[3] = 1'b1;
        IRQ_IN[1] = 1'b1;
        repeat (8) step();
        PORT_ID = 8'h33; #1;
        n_checks++;
        if (IN_DATA !== 8'h0A) begin n_fail++; $display("FAIL prio_stat: got %h want 0a", IN_DATA); end
        PORT_ID = 8'h34; #1;
        n_checks++;
        if (IN_DATA !== 8'h01) begin n_fail++; $display("FAIL prio_id_1: got %h want 01", IN_DATA); end
        wr(8'h32, 8'h02);
        PORT_ID = 8'h34; #1;
        n_checks++;
        if (IN_DATA !== 8'h03 || INT !== 1'b1) begin
            n_fail++; $display("FAIL prio_id_3: id %h int %b want 03/1", IN_DATA, INT);
        end
        step();
        n_checks++;
        if (INT !== 1'b1) begin n_fail++; $display("FAIL prio_int_held: got %b want 1", INT); end
        wr(8'h32, 8'h08);
        PORT_ID = 8'h34; #1;
        n_checks++;
        if (IN_DATA !== 8'hFF) begin n_fail++; $display("FAIL prio_id_none: got %h want ff", IN_DATA); end
        step();
        n_checks++;
        if (INT !== 1'b0) begin n_fail++; $display("FAIL prio_int_drop: got %b want 0", INT); end
        IRQ_IN = '0;
        repeat (8) step();
    endtask

    task automatic test_collision();
        IRQ_IN[0] = 1'b1;
        repeat (6) step();
        IO_STRB = 1'b1; PORT_ID = 8'h32; OUT_PORT = 8'h01;
        step();
        IO_STRB = 1'b0;
        n_checks++;
        if (PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL collision_set_wins: pend %b want bit0=1", PENDING); end
        wr(8'h32, 8'h01);
        n_checks++;
        if (PENDING !== 4'b0000) begin n_fail++; $display("FAIL collision_later_clr: pend %b want 0000", PENDING); end
    endtask

    task automatic test_level_mode();
        wr(8'h31, 8'h01);
        step();
        PORT_ID = 8'h31; #1;
        n_checks++;
        if (PENDING[0] !== 1'b1 || IN_DATA !== 8'h01) begin
            n_fail++; $display("FAIL level_follow: pend %b mode %h want bit0=1/01", PENDING, IN_DATA);
        end
        wr(8'h32, 8'h01);
        step();
        n_checks++;
        if (PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL level_clr_ignored: pend %b want bit0=1", PENDING); end
        IRQ_IN[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) begin
                n_checks++;
                if (PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL level_fall_early: pend %b want bit0=1", PENDING); end
            end
            if (e == 7) begin
                n_checks++;
                if (PENDING[0] !== 1'b0) begin n_fail++; $display("FAIL level_fall: pend %b want bit0=0", PENDING); end
            end
        end
        IRQ_IN[0] = 1'b1;
        repeat (8) step();
        wr(8'h31, 8'h00);
        IRQ_IN[0] = 1'b0;
        repeat (8) step();
        n_checks++;
        if (PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL mode_switch_keeps: pend %b want bit0=1", PENDING); end
        wr(8'h32, 8'h01);
        n_checks++;
        if (PENDING !== 4'b0000) begin n_fail++; $display("FAIL mode_switch_clr: pend %b want 0000", PENDING); end
    endtask

    task automatic test_mask_reset();
        IRQ_IN[2] = 1'b1;
        repeat (8) step();
        wr(8'h30, 8'h00);
        step();
        n_checks++;
        if (INT !== 1'b0) begin n_fail++; $display("FAIL masked_int: got %b want 0", INT); end
        PORT_ID = 8'h33; #1;
        n_checks++;
        if (IN_DATA !== 8'h04) begin n_fail++; $display("FAIL masked_stat: got %h want 04", IN_DATA); end
        PORT_ID = 8'h34; #1;
        n_checks++;
        if (IN_DATA !== 8'hFF) begin n_fail++; $display("FAIL masked_id: got %h want ff", IN_DATA); end
        IRQ_IN[3] = 1'b1;
        repeat (8) step();
        n_checks++;
        if (PENDING !== 4'b1100 || INT !== 1'b0) begin
            n_fail++; $display("FAIL masked_latch: pend %b int %b want 1100/0", PENDING, INT);
        end
        wr(8'h30, 8'h0F);
        IRQ_IN = '0;
        repeat (8) step();
        IRQ_IN[2] = 1'b1;
        repeat (3) step();
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        PORT_ID = 8'h33; #1;
        n_checks++;
        if ({PENDING, INT, IN_DATA} !== 13'h0) begin
            n_fail++; $display("FAIL async_reset: pend %b int %b stat %h want all 0", PENDING, INT, IN_DATA);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) begin
                n_checks++;
                if (PENDING !== 4'b0000) begin n_fail++; $display("FAIL reset_no_spurious: pend %b want 0000", PENDING); end
            end
            if (e == 7) begin
                n_checks++;
                if (PENDING !== 4'b0100) begin n_fail++; $display("FAIL reset_fresh_rise: pend %b want 0100", PENDING); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_in;
        for (int k = 0; k < 800; k++) begin
            IO_STRB = 1'b0;
            for (int c = 0; c < NC; c++) if ($urandom_range(0, 5) == 0) IRQ_IN[c] = ~IRQ_IN[c];
            OUT_PORT = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                IO_STRB = 1'b1;
                PORT_ID = 8'h30 + 8'($urandom_range(0, 2));
            end else if ($urandom_range(0, 7) == 0) begin
                PORT_ID = 8'($urandom);
            end else begin
                PORT_ID = 8'h30 + 8'($urandom_range(0, 5));
            end
            step();
            exp_in = m_in_data(PORT_ID);
            n_checks++;
            if (PENDING !== m_pend) begin n_fail++; $display("FAIL rand_pending: cycle %0d got %b want %b", k, PENDING, m_pend); end
            n_checks++;
            if (INT !== m_int) begin n_fail++; $display("FAIL rand_int: cycle %0d got %b want %b", k, INT, m_int); end
            n_checks++;
            if (IN_DATA !== exp_in) begin
                n_fail++; $display("FAIL rand_in_data: cycle %0d port %h got %h want %h", k, PORT_ID, IN_DATA, exp_in);
            end
        end
        IO_STRB = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_glitch();
        test_edge_latency();
        test_priority_w1c();
        test_collision();
        test_level_mode();
        test_mask_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_intr_ctrl.md
Name: rat_intr_ctrl

Overview:
- Parametrised interrupt controller for the RAT MCU. It replaces the single debounced-button interrupt with NUM_CH independent sources.
- Each source is synchronised, debounced and edge- or level-qualified, then latched in a pending register.
- A maskable, priority-encoded INT line drives the CPU interrupt input.
- The CPU sees mask, mode, status and highest-priority ID through the existing IN/OUT port bus.

Parameters:
- NUM_CH, 4, number of interrupt sources (1..8).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced level changes (>=2).
- MASK_PORT, 8'h30, port ID of the mask register (R/W).
- MODE_PORT, 8'h31, port ID of the mode register (R/W); bit=1 means level mode, 0 means edge mode.
- CLR_PORT, 8'h32, port ID for write-1-to-clear of pending bits (write only; reads return 0).
- STAT_PORT, 8'h33, port ID for pending status (read only).
- ID_PORT, 8'h34, port ID for the highest-priority active ID (read only).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- IRQ_IN  in  NUM_CH  raw asynchronous interrupt sources (buttons, peripherals)
- IO_STRB  in  1  CPU output strobe; a write occurs on a cycle with IO_STRB=1
- PORT_ID  in  8  CPU port address
- OUT_PORT  in  8  CPU write data
- IN_DATA  out  8  read data for the CPU input mux
- INT  out  1  interrupt request to the CPU
- PENDING  out  NUM_CH  pending register, for debug/LEDs

Behaviour:
- Reset (RST_N=0, async) sets: sync flops, debounced levels, counters, PENDING, mask and mode to 0; INT=0. IN_DATA is combinational and reflects the reset register contents.
- Per-channel pipeline:
  - 2-FF synchroniser feeds the counter.
  - Counter clears when the sync output equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
- Edge mode: a debounced 0->1 transition sets PENDING[i] on the next edge. The bit holds until cleared by a CLR_PORT write.
- Level mode: PENDING[i] = registered debounced level. CLR writes have no lasting effect while the level is high.
- Latency from IRQ_IN rise (held stable) to effects:
  - debounced level rises at rising edge 2+DEBOUNCE_CYCLES;
  - PENDING at edge 3+DEBOUNCE_CYCLES;
  - INT at edge 4+DEBOUNCE_CYCLES.
- INT is registered: INT <= |(PENDING & mask).
- Writes take effect on the clock edge where IO_STRB=1 and PORT_ID matches. Only bits [NUM_CH-1:0] are used; upper bits are ignored.
- Edge set and CLR of the same bit in the same cycle: the set wins, so the bit stays pending.
- Mask change affects INT on the following edge. A masked channel still latches PENDING.
- Changing a channel's mode from level to edge leaves its PENDING value as-is.
- IN_DATA (combinational, zero-extended to 8 bits), by PORT_ID:
  - MASK_PORT: mask register.
  - MODE_PORT: mode register.
  - STAT_PORT: PENDING.
  - ID_PORT: index of the lowest-numbered set bit of PENDING & mask (channel 0 = highest priority); 8'hFF if none.
  - Any other PORT_ID: 8'h00.
- RST_N asserted mid-debounce or with interrupts pending: everything clears immediately. No spurious edge is generated after release, even if IRQ_IN is already high; the rise is debounced as a fresh event.

Decomposition:
- Package rat_io_pkg holds:
  - port-ID constants (defaults above);
  - ID_NONE = 8'hFF;
  - MAX_CH = 8;
  - mode encoding constants MODE_EDGE = 1'b0, MODE_LEVEL = 1'b1.
- Sub-module irq_debounce holds one channel's synchroniser, debounce counter and rising-edge one-shot. Parameter DEBOUNCE_CYCLES; outputs: level and rise pulse. It is instantiated NUM_CH times with a generate loop.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=4):
- Glitch rejection: after reset, write MASK=8'h0F. Pulse IRQ_IN[1] high for 3 cycles, then low -> PENDING stays 0, INT stays 0.
- Edge latency: MASK=8'h0F, IRQ_IN[2] rises and is held -> PENDING=4'b0100 at edge 7, INT=1 at edge 8, ID_PORT reads 8'h02.
- Priority and W1C:
  - With channels 3 and 1 pending, ID reads 8'h01.
  - Write CLR=8'h02 -> ID reads 8'h03, INT stays 1.
  - Write CLR=8'h08 -> ID 8'hFF, INT=0 on the next edge.
- Set/clear collision: CLR write to bit 0 on the same cycle as its debounced rise -> PENDING[0]=1 after the edge.
- Level mode: MODE=8'h01, IRQ_IN[0] held high -> PENDING[0]=1. CLR=8'h01 write -> bit remains 1. Release IRQ_IN[0] -> PENDING[0]=0 DEBOUNCE_CYCLES+1 cycles after the sync output falls.
- Masking and reset:
  - MASK=0 with channel 2 pending -> INT=0, STAT reads 8'h04, ID reads 8'hFF.
  - Assert RST_N low mid-debounce -> all outputs 0 asynchronously.
  - Release with IRQ_IN[2] already high -> PENDING[2] sets at edge 7 after release, not earlier.
